// File: rtl/ttl74x194.sv
// rtl/ttl74x194.sv - parameterised 74x194 bidirectional universal shift register
module ttl74x194 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             s0,
    input  logic             s1,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= '0;
        end else begin
            // Unknown mode bits fall to the default so the violation propagates as X.
            case ({s1, s0})
                2'b00:   q <= q;
                2'b01:   q <= {q[WIDTH-2:0], dsr};
                2'b10:   q <= {dsl, q[WIDTH-1:1]};
                2'b11:   q <= d;
                default: q <= {WIDTH{1'bx}};
            endcase
        end
    end

endmodule

// File: tb/tb_ttl74x194.sv
// tb/tb_ttl74x194.sv - scoreboard bench for ttl74x194 incl. cascade vs wide reference
module tb_ttl74x194;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       s0 = 1'b0, s1 = 1'b0, dsr = 1'b0, dsl = 1'b0;
    logic [3:0] d = 4'h0;
    logic [3:0] q;

    logic       cclr = 1'b0;
    logic       cs0 = 1'b0, cs1 = 1'b0, cdsr = 1'b0, cdsl = 1'b0;
    logic [7:0] cd = 8'h00;
    logic [3:0] lo_q, hi_q;
    logic [7:0] ref_q;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } sb_t;
    sb_t sbq[$];

    always #5 clk = ~clk;

    ttl74x194 #(.WIDTH(4)) dut (
        .clk(clk), .clr(clr), .s0(s0), .s1(s1), .dsr(dsr), .dsl(dsl), .d(d), .q(q)
    );

    ttl74x194 #(.WIDTH(4)) u_lo (
        .clk(clk), .clr(cclr), .s0(cs0), .s1(cs1), .dsr(cdsr), .dsl(hi_q[0]),
        .d(cd[3:0]), .q(lo_q)
    );

    ttl74x194 #(.WIDTH(4)) u_hi (
        .clk(clk), .clr(cclr), .s0(cs0), .s1(cs1), .dsr(lo_q[3]), .dsl(cdsl),
        .d(cd[7:4]), .q(hi_q)
    );

    ttl74x194 #(.WIDTH(8)) u_ref (
        .clk(clk), .clr(cclr), .s0(cs0), .s1(cs1), .dsr(cdsr), .dsl(cdsl), .d(cd), .q(ref_q)
    );

    function automatic logic mux153(input logic [3:0] c, input logic b, input logic a,
                                    input logic en_n);
        logic [1:0] sel;
        sel = {b, a};
        return en_n ? 1'b0 : c[sel];
    endfunction

    task automatic push(input string tag, input logic [7:0] v);
        sb_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        sb_t e;
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty observed=%h expected=<none>", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val)
            else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive(input logic [1:0] mode, input logic [3:0] dv, input logic r,
                         input logic l);
        {s1, s0} = mode;
        d   = dv;
        dsr = r;
        dsl = l;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [1:0] mode, input logic [3:0] dv,
                        input logic r, input logic l, input logic [3:0] exp);
        drive(mode, dv, r, l);
        push(tag, {4'h0, exp});
        tick();
        check({4'h0, q});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] model;
        logic [1:0] m;
        logic [3:0] mux_c;
        logic       bit_in;

        // Reset held across an edge.
        push("reset", 8'h00);
        tick();
        check({4'h0, q});
        clr = 1'b1;

        // Async clear between edges, then clear holds against load.
        step("load_1010", 2'b11, 4'b1010, 1'b0, 1'b0, 4'b1010);
        clr = 1'b0;
        #1;
        push("clr_async", 8'h00);
        check({4'h0, q});
        for (int i = 0; i < 3; i++) step("clr_hold", 2'b11, 4'b1111, 1'b1, 1'b1, 4'b0000);
        clr = 1'b1;

        // Clear falling in the same timestep as a rising edge.
        step("load_1010b", 2'b11, 4'b1010, 1'b0, 1'b0, 4'b1010);
        drive(2'b11, 4'b1111, 1'b0, 1'b0);
        @(posedge clk);
        clr = 1'b0;
        #1;
        push("clr_edge", 8'h00);
        check({4'h0, q});
        #2;
        clr = 1'b1;

        // Load then hold with unused inputs toggling.
        step("load_1011", 2'b11, 4'b1011, 1'b0, 1'b0, 4'b1011);
        for (int i = 0; i < 4; i++) begin
            bit_in = i[0];
            step("hold", 2'b00, {4{~bit_in}}, bit_in, ~bit_in, 4'b1011);
        end

        // Shift right.
        step("sr_load0", 2'b11, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("sr1", 2'b01, 4'b1111, 1'b1, 1'b0, 4'b0001);
        step("sr2", 2'b01, 4'b1111, 1'b0, 1'b1, 4'b0010);
        step("sr3", 2'b01, 4'b1111, 1'b1, 1'b0, 4'b0101);
        step("sr4", 2'b01, 4'b1111, 1'b1, 1'b0, 4'b1011);
        step("sr5", 2'b01, 4'b1111, 1'b0, 1'b1, 4'b0110);

        // Shift left.
        step("sl_load0", 2'b11, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("sl1", 2'b10, 4'b1111, 1'b0, 1'b1, 4'b1000);
        step("sl2", 2'b10, 4'b1111, 1'b1, 1'b1, 4'b1100);
        step("sl3", 2'b10, 4'b1111, 1'b1, 1'b0, 4'b0110);
        step("sl4", 2'b10, 4'b1111, 1'b0, 1'b1, 4'b1011);
        step("sl5", 2'b10, 4'b1111, 1'b1, 1'b0, 4'b0101);

        // 74x153 y1 feeding dsr; c13..c10 = 0110.
        mux_c = 4'b0110;
        step("mux_load0", 2'b11, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("mux_s0", 2'b01, 4'h0, mux153(mux_c, 1'b0, 1'b0, 1'b0), 1'b0, 4'b0000);
        step("mux_s1", 2'b01, 4'h0, mux153(mux_c, 1'b0, 1'b1, 1'b0), 1'b0, 4'b0001);
        step("mux_s2", 2'b01, 4'h0, mux153(mux_c, 1'b1, 1'b0, 1'b0), 1'b0, 4'b0011);
        step("mux_s3", 2'b01, 4'h0, mux153(mux_c, 1'b1, 1'b1, 1'b0), 1'b0, 4'b0110);
        step("mux_dis0", 2'b01, 4'h0, mux153(mux_c, 1'b0, 1'b0, 1'b1), 1'b0, 4'b1100);
        step("mux_dis1", 2'b01, 4'h0, mux153(mux_c, 1'b0, 1'b1, 1'b1), 1'b0, 4'b1000);
        step("mux_dis2", 2'b01, 4'h0, mux153(mux_c, 1'b1, 1'b0, 1'b1), 1'b0, 4'b0000);
        step("mux_dis3", 2'b01, 4'h0, mux153(mux_c, 1'b1, 1'b1, 1'b1), 1'b0, 4'b0000);

        // Cascade of two 4-bit parts against an 8-bit part and an 8-bit model.
        push("casc_reset", 8'h00);
        check(ref_q);
        cclr  = 1'b1;
        model = 8'h00;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc == 100) begin
                cclr  = 1'b0;
                #1;
                model = 8'h00;
                push("midclr_ref", model);
                push("midclr_casc", model);
                check(ref_q);
                check({hi_q, lo_q});
                cclr = 1'b1;
            end
            m    = 2'($urandom_range(0, 3));
            {cs1, cs0} = m;
            cd   = 8'($urandom);
            cdsr = 1'($urandom);
            cdsl = 1'($urandom);
            case (m)
                2'b00:   model = model;
                2'b01:   model = {model[6:0], cdsr};
                2'b10:   model = {cdsl, model[7:1]};
                default: model = cd;
            endcase
            push("casc_ref", model);
            push("casc_pair", model);
            @(posedge clk);
            #1;
            check(ref_q);
            check({hi_q, lo_q});
        end

        if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
